ahb_sram_ws: RTL and testbench
==============================

Name: ahb_sram_ws

Overview:
- Parametrised AHB-Lite SRAM slave model for the verification benches.
- Generalises the fixed 32-bit delay SRAM with configurable data width and size.
- Adds deterministic wait-state modes (none / fixed / LFSR pseudo-random), a programmable address-window error injector with a protocol-correct two-cycle ERROR response, and access statistics counters.
- Sits on the bench AHB fabric as an instruction or data memory behind the decoder.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; 32 or 64 only
MEMSIZE, 4096, memory size in bytes; power of two, at least DATA_WIDTH/8
LFSR_SEED, 16'hACE1, reset value of the wait-state LFSR; must be non-zero

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
clk_strobe  in  1  clock enable; no state advances when 0
hsel  in  1  slave select
base_addr  in  ADDR_WIDTH  memory base address
haddr  in  ADDR_WIDTH  address
hwrite  in  1  1 = write
hsize  in  3  transfer size
hburst  in  3  burst type; accepted, not checked
htrans  in  2  transfer type
hready  in  1  bus ready
hwdata  in  DATA_WIDTH  write data
hreadyout  out  1  slave ready
hresp  out  1  1 = ERROR
hrdata  out  DATA_WIDTH  read data
ws_mode  in  2  0 none, 1 fixed, 2 LFSR, 3 reserved (treated as 0)
ws_fixed  in  8  wait count (mode 1) or LFSR mask (mode 2)
err_en  in  1  enable error injection
err_addr  in  ADDR_WIDTH  error window address
err_mask  in  ADDR_WIDTH  error window: error when (haddr & ~err_mask) == (err_addr & ~err_mask)
rd_cnt  out  32  completed OKAY reads
wr_cnt  out  32  completed OKAY writes
err_cnt  out  32  ERROR responses issued

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, all counters=0, LFSR=LFSR_SEED, FSM=IDLE. An asynchronous reset mid-transfer aborts the transfer; a pending write is not committed.
- Accept condition: clk_strobe & hsel & hready & htrans[1]. On accept, the block latches addr offset, hwrite and hsize, and computes wait count W:
  - mode 0: W=0
  - mode 1: W=ws_fixed
  - mode 2: W=LFSR[7:0] & ws_fixed
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances once per accept, after W is sampled.
- Error classes, evaluated at accept:
  - out of range: haddr < base_addr or haddr >= base_addr+MEMSIZE
  - unaligned: haddr not aligned to 2^hsize
  - oversize: 2^hsize > DATA_WIDTH/8
  - err_en and window match
- FSM states:
  - IDLE: an accept with W=0 and no error goes to DATA; with W>0 goes to WAIT (cnt=W); with an error and W=0 goes to ERR1.
  - WAIT: hreadyout=0, hresp=0. cnt decrements each strobe. At cnt==1, go to DATA, or to ERR1 if the transfer errors.
  - DATA: hreadyout=1, hresp=0. The transfer completes this cycle. A new accept in the same cycle is handled exactly as from IDLE; otherwise return to IDLE.
  - ERR1: hreadyout=0, hresp=1. Go to ERR2.
  - ERR2: hreadyout=1, hresp=1, err_cnt++. Any accept in this cycle is handled as from IDLE. Writes that error never modify memory.
- With W=0 and no error, hreadyout stays 1 throughout; there is one data-phase cycle per transfer.
- Write commit: at the strobe edge ending DATA. Only byte lanes selected by hsize and the address low bits are written from hwdata. wr_cnt++.
- Read: hrdata = mem word at latched offset, combinational, while in DATA for a read; 0 in every other state. rd_cnt++ at the DATA edge.
- Read-after-write: back-to-back write then read to the same address returns the new data, because the write commits before the read's DATA cycle.
- Counters wrap at 2^32.
- clk_strobe=0 freezes the FSM, counters, LFSR and memory. Outputs hold.
- htrans IDLE/BUSY: no response beyond OKAY; the FSM is unaffected.

Test Plan:
1. ws_mode=0, DATA_WIDTH=32. Write 32'hDEADBEEF to base+0x10, then read it back-to-back -> hreadyout never 0, hrdata=32'hDEADBEEF in the read data phase, wr_cnt=1, rd_cnt=1.
2. ws_mode=1, ws_fixed=3. Single read -> exactly 3 cycles of hreadyout=0, then 1 DATA cycle with hresp=0.
3. Byte write 8'h5A to offset 0x3 over word 32'h11223344 (hsize=0) -> readback 32'h5A223344. Halfword write at offset 0x1 -> ERROR (unaligned), memory unchanged, err_cnt=1.
4. err_en=1, err_addr=base+0x100, err_mask=0xFF, ws_mode=1, ws_fixed=2. Write to base+0x1F0 -> hresp pattern 0,0,1,1 with hreadyout 0,0,0,1; memory unchanged.
5. ws_mode=2, ws_fixed=8'h07, 16 reads -> each W equals the reference LFSR[7:0]&7 sequence from seed 16'hACE1; apply rstn low mid-WAIT -> outputs return to reset values immediately.
6. Run 4 accesses with clk_strobe toggled every other cycle -> identical response sequence to the same stimulus with clk_strobe=1, each state stretched 2x.

Source files
------------

// File: rtl/ahb_sram_ws_if.sv
// AHB-Lite bus bundle between a bench master/fabric and the ahb_sram_ws slave.
//   master : drives hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata
//            and observes hreadyout, hresp, hrdata
//   slave  : the mirror image
// hready is the fabric-level ready; a single-slave bench ties it to hreadyout.
interface ahb_sram_ws_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [1:0]            htrans;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave model with configurable wait states, address-window
// error injection and access statistics.
// Ports:
//   clk, rstn (async, active-low), clk_strobe (clock enable for all state)
//   bus        : AHB-Lite slave side (ahb_sram_ws_if.slave)
//   base_addr  : base address of the memory window (MEMSIZE bytes)
//   ws_mode    : 0 none, 1 fixed (ws_fixed), 2 LFSR & ws_fixed, 3 as 0
//   ws_fixed   : wait count or LFSR mask
//   err_en/err_addr/err_mask : forced-ERROR address window
//   rd_cnt/wr_cnt/err_cnt    : completed OKAY reads/writes, ERROR responses
module ahb_sram_ws #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          MEMSIZE    = 4096,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clk_strobe,
  ahb_sram_ws_if.slave          bus,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [1:0]            ws_mode,
  input  logic [7:0]            ws_fixed,
  input  logic                  err_en,
  input  logic [ADDR_WIDTH-1:0] err_addr,
  input  logic [ADDR_WIDTH-1:0] err_mask,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           err_cnt
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int OFF_W  = $clog2(MEMSIZE);
  localparam int DEPTH  = MEMSIZE / BYTES;
  localparam int WIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]          MAX_SIZE = 3'(LANE_W);
  localparam logic [ADDR_WIDTH:0] MEM_SPAN = (ADDR_WIDTH+1)'(MEMSIZE);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state, nxt;
  logic [7:0]            cnt;
  logic                  write_q;
  logic                  err_q;
  logic [15:0]           lfsr;
  logic [OFF_W-1:0]      off_q;
  logic [BYTES-1:0]      be_q;
  logic [WIDX_W-1:0]     widx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range, unaligned, oversize, win_hit, acc_err;
  logic [7:0]            ws_cnt;
  logic [ADDR_WIDTH:0]   addr_ext, base_ext;
  logic                  unused_bits;

  // Byte lanes touched by a transfer of 2^size bytes starting at lane lo.
  function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size,
                                                 input logic [LANE_W-1:0] lo);
    logic [BYTES-1:0] m;
    int first, last;
    first = int'(lo);
    last  = first + (1 << size);
    for (int b = 0; b < BYTES; b++)
      m[b] = (b >= first) && (b < last);
    return m;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Address phase: accept qualification, error classification, wait count.
  assign addr_ext  = {1'b0, bus.haddr};
  assign base_ext  = {1'b0, base_addr};
  assign in_range  = (addr_ext >= base_ext) && (addr_ext < base_ext + MEM_SPAN);
  assign unaligned = (bus.haddr & ((ADDR_WIDTH'(1) << bus.hsize) - ADDR_WIDTH'(1))) != '0;
  assign oversize  = bus.hsize > MAX_SIZE;
  assign win_hit   = err_en && ((bus.haddr & ~err_mask) == (err_addr & ~err_mask));
  assign acc_err   = !in_range || unaligned || oversize || win_hit;

  // Only states that present hreadyout=1 can take a new address phase.
  assign accept = clk_strobe && bus.hsel && bus.hready && bus.htrans[1] &&
                  (state == S_IDLE || state == S_DATA || state == S_ERR2);

  assign unused_bits = ^{bus.hburst, bus.htrans[0]};

  always_comb begin
    case (ws_mode)
      2'd1:    ws_cnt = ws_fixed;
      2'd2:    ws_cnt = lfsr[7:0] & ws_fixed;
      default: ws_cnt = 8'd0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT:  if (cnt == 8'd1) nxt = err_q ? S_ERR1 : S_DATA;
      S_ERR1:  nxt = S_ERR2;
      default: begin
        if (!accept)            nxt = S_IDLE;
        else if (ws_cnt != 8'd0) nxt = S_WAIT;
        else if (acc_err)       nxt = S_ERR1;
        else                    nxt = S_DATA;
      end
    endcase
  end

  // Control state, registered bus response and statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      bus.hreadyout <= 1'b1;
      bus.hresp     <= 1'b0;
      cnt           <= 8'd0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      lfsr          <= LFSR_SEED;
      rd_cnt        <= 32'd0;
      wr_cnt        <= 32'd0;
      err_cnt       <= 32'd0;
    end else if (clk_strobe) begin
      state         <= nxt;
      bus.hreadyout <= (nxt == S_IDLE) || (nxt == S_DATA) || (nxt == S_ERR2);
      bus.hresp     <= (nxt == S_ERR1) || (nxt == S_ERR2);
      if (state == S_WAIT) cnt <= cnt - 8'd1;
      if (accept) begin
        cnt     <= ws_cnt;
        write_q <= bus.hwrite;
        err_q   <= acc_err;
        lfsr    <= lfsr_step(lfsr);
      end
      if (state == S_DATA) begin
        if (write_q) wr_cnt <= wr_cnt + 32'd1;
        else         rd_cnt <= rd_cnt + 32'd1;
      end
      if (state == S_ERR2) err_cnt <= err_cnt + 32'd1;
    end
  end

  // Address-phase capture; only consumed in DATA, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      off_q <= OFF_W'(bus.haddr - base_addr);
      be_q  <= lane_mask(bus.hsize, bus.haddr[LANE_W-1:0]);
    end
  end

  assign widx = WIDX_W'(off_q >> LANE_W);

  // Data phase: write commits on the edge that ends DATA.
  always_ff @(posedge clk) begin
    if (rstn && clk_strobe && state == S_DATA && write_q) begin
      for (int b = 0; b < BYTES; b++)
        if (be_q[b]) mem[widx][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  assign bus.hrdata = (state == S_DATA && !write_q) ? mem[widx] : '0;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Directed bench for ahb_sram_ws: zero-wait write/read, fixed and LFSR wait
// states, byte lanes, alignment/oversize/range/window errors, async reset
// during a wait, and clock-enable stretching.
module tb_ahb_sram_ws;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 4096;
  localparam logic [AW-1:0] BASE = 32'h1000_0000;

  logic          clk        = 1'b0;
  logic          rstn       = 1'b0;
  logic          clk_strobe = 1'b1;
  logic [AW-1:0] base_addr, err_addr, err_mask;
  logic [1:0]    ws_mode;
  logic [7:0]    ws_fixed;
  logic          err_en;
  logic [31:0]   rd_cnt, wr_cnt, err_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  ahb_sram_ws_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  assign bus.hready = bus.hreadyout;

  ahb_sram_ws #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMSIZE(MS), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rstn(rstn), .clk_strobe(clk_strobe), .bus(bus),
    .base_addr(base_addr), .ws_mode(ws_mode), .ws_fixed(ws_fixed),
    .err_en(err_en), .err_addr(err_addr), .err_mask(err_mask),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd2;
    bus.hburst = 3'd0;
    bus.hwdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_bus();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Single non-pipelined transfer; trace collects {hreadyout,hresp} per data-phase cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic resp, output logic [31:0] trace);
    bus.hsel = 1'b1; bus.haddr = a; bus.hwrite = w; bus.hsize = sz; bus.htrans = 2'b10;
    @(negedge clk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wd;
    waits = 0;
    trace = {30'd0, bus.hreadyout, bus.hresp};
    while (!bus.hreadyout && waits < 300) begin
      @(negedge clk);
      waits++;
      trace = {trace[29:0], bus.hreadyout, bus.hresp};
    end
    check("xfer completes", 64'(bus.hreadyout), 64'(1));
    rd   = bus.hrdata;
    resp = bus.hresp;
    @(negedge clk);
  endtask

  task automatic run_step(input logic tg, input logic sel, input logic [31:0] a,
                          input logic w, input logic [31:0] wd, input logic [1:0] exp_rs,
                          input logic [31:0] exp_rd, input string tag);
    bus.hsel = sel; bus.htrans = sel ? 2'b10 : 2'b00; bus.haddr = a;
    bus.hwrite = w; bus.hsize = 3'd2; bus.hwdata = wd;
    clk_strobe = 1'b1;
    @(negedge clk);
    check(tag, 64'({bus.hreadyout, bus.hresp, bus.hrdata}), 64'({exp_rs, exp_rd}));
    if (tg) begin
      clk_strobe = 1'b0;
      @(negedge clk);
      check({tag, " held"}, 64'({bus.hreadyout, bus.hresp, bus.hrdata}), 64'({exp_rs, exp_rd}));
    end
  endtask

  task automatic run_seq(input logic tg, input string nm);
    logic [31:0] a, e, d;
    a = BASE + 32'h40; e = BASE + 32'(MS); d = 32'hCAFE_0001;
    run_step(tg, 1, a, 1, d, 2'b00, 0, {nm, " wr s0"});
    run_step(tg, 0, a, 1, d, 2'b10, 0, {nm, " wr s1"});
    run_step(tg, 0, a, 1, d, 2'b10, 0, {nm, " wr s2"});
    run_step(tg, 1, a, 0, 0, 2'b00, 0, {nm, " rd s0"});
    run_step(tg, 0, a, 0, 0, 2'b10, d, {nm, " rd s1"});
    run_step(tg, 0, a, 0, 0, 2'b10, 0, {nm, " rd s2"});
    run_step(tg, 1, e, 0, 0, 2'b00, 0, {nm, " er s0"});
    run_step(tg, 0, e, 0, 0, 2'b01, 0, {nm, " er s1"});
    run_step(tg, 0, e, 0, 0, 2'b11, 0, {nm, " er s2"});
    run_step(tg, 0, e, 0, 0, 2'b10, 0, {nm, " er s3"});
    run_step(tg, 1, a, 0, 0, 2'b00, 0, {nm, " rd2 s0"});
    run_step(tg, 0, a, 0, 0, 2'b10, d, {nm, " rd2 s1"});
    run_step(tg, 0, a, 0, 0, 2'b10, 0, {nm, " rd2 s2"});
    clk_strobe = 1'b1;
    idle_bus();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, tr;
    logic        resp;
    int          waits;
    logic [15:0] m;
    logic [7:0]  exp_w;

    idle_bus();
    base_addr = BASE; ws_mode = 2'd0; ws_fixed = 8'd0;
    err_en = 1'b0; err_addr = '0; err_mask = '0;
    repeat (3) @(negedge clk);
    check("rst hreadyout", 64'(bus.hreadyout), 64'(1));
    check("rst hresp",     64'(bus.hresp),     64'(0));
    check("rst hrdata",    64'(bus.hrdata),    64'(0));
    check("rst counters",  64'({rd_cnt, wr_cnt} | 64'(err_cnt)), 64'(0));
    rstn = 1'b1;
    @(negedge clk);

    // 1: zero-wait write then pipelined read of the same word
    bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = BASE + 32'h10; bus.hwrite = 1; bus.hsize = 3'd2;
    @(negedge clk);
    check("t1 wr rdy", 64'(bus.hreadyout), 64'(1));
    bus.hwdata = 32'hDEAD_BEEF; bus.hwrite = 0;
    @(negedge clk);
    check("t1 rd rdy",   64'(bus.hreadyout), 64'(1));
    check("t1 rd hresp", 64'(bus.hresp),     64'(0));
    check("t1 rdata",    64'(bus.hrdata),    64'(32'hDEAD_BEEF));
    idle_bus();
    @(negedge clk);
    check("t1 idle rdy", 64'(bus.hreadyout), 64'(1));
    check("t1 wr_cnt",   64'(wr_cnt), 64'(1));
    check("t1 rd_cnt",   64'(rd_cnt), 64'(1));

    // 2: fixed three wait states
    do_reset();
    ws_mode = 2'd1; ws_fixed = 8'd3;
    xfer(BASE + 32'h10, 0, 3'd2, 0, rd, waits, resp, tr);
    check("t2 waits", 64'(waits), 64'(3));
    check("t2 trace", 64'(tr),    64'(32'h2));
    check("t2 resp",  64'(resp),  64'(0));
    check("t2 rdata", 64'(rd),    64'(32'hDEAD_BEEF));

    // 3: byte lane write, unaligned and oversize errors
    do_reset();
    ws_mode = 2'd0;
    xfer(BASE + 32'h20, 1, 3'd2, 32'h1122_3344, rd, waits, resp, tr);
    xfer(BASE + 32'h23, 1, 3'd0, 32'h5A00_0000, rd, waits, resp, tr);
    xfer(BASE + 32'h20, 0, 3'd2, 0, rd, waits, resp, tr);
    check("t3 byte merge", 64'(rd), 64'(32'h5A22_3344));
    xfer(BASE + 32'h21, 1, 3'd1, 32'hFFFF_FFFF, rd, waits, resp, tr);
    check("t3 unaligned resp",  64'(resp), 64'(1));
    check("t3 unaligned trace", 64'(tr),   64'(32'h7));
    xfer(BASE + 32'h20, 0, 3'd2, 0, rd, waits, resp, tr);
    check("t3 mem unchanged", 64'(rd), 64'(32'h5A22_3344));
    check("t3 err_cnt", 64'(err_cnt), 64'(1));
    xfer(BASE + 32'h28, 0, 3'd3, 0, rd, waits, resp, tr);
    check("t3 oversize resp", 64'(resp), 64'(1));
    check("t3 counters", 64'({wr_cnt, rd_cnt}), {32'd2, 32'd2});
    check("t3 err_cnt2", 64'(err_cnt), 64'(2));

    // 4: window error after two wait states
    do_reset();
    xfer(BASE + 32'h1F0, 1, 3'd2, 32'h0BAD_F00D, rd, waits, resp, tr);
    err_en = 1; err_addr = BASE + 32'h100; err_mask = 32'hFF; ws_mode = 2'd1; ws_fixed = 8'd2;
    xfer(BASE + 32'h1F0, 1, 3'd2, 32'hFFFF_FFFF, rd, waits, resp, tr);
    check("t4 trace", 64'(tr),    64'(32'h7));
    check("t4 waits", 64'(waits), 64'(3));
    err_en = 0; ws_mode = 2'd0;
    xfer(BASE + 32'h1F0, 0, 3'd2, 0, rd, waits, resp, tr);
    check("t4 mem unchanged", 64'(rd), 64'(32'h0BAD_F00D));
    check("t4 err_cnt", 64'(err_cnt), 64'(1));
    check("t4 wr_cnt",  64'(wr_cnt),  64'(1));

    // 5: LFSR wait states, then async reset in the middle of a wait
    do_reset();
    ws_mode = 2'd2; ws_fixed = 8'h07;
    m = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      exp_w = m[7:0] & 8'h07;
      xfer(BASE + 32'(4 * i), 0, 3'd2, 0, rd, waits, resp, tr);
      check($sformatf("t5 lfsr w%0d", i), 64'(waits), 64'(exp_w));
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
    check("t5 rd_cnt", 64'(rd_cnt), 64'(16));
    ws_mode = 2'd1; ws_fixed = 8'd5;
    bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = BASE; bus.hwrite = 0; bus.hsize = 3'd2;
    @(negedge clk);
    idle_bus();
    check("t5 in wait", 64'(bus.hreadyout), 64'(0));
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t5 rst rdy",    64'(bus.hreadyout), 64'(1));
    check("t5 rst hresp",  64'(bus.hresp),     64'(0));
    check("t5 rst hrdata", 64'(bus.hrdata),    64'(0));
    check("t5 rst rd_cnt", 64'(rd_cnt),        64'(0));
    @(negedge clk);
    rstn = 1'b1;

    // 6: identical responses with clk_strobe at half rate
    do_reset();
    ws_mode = 2'd1; ws_fixed = 8'd1;
    run_seq(1'b0, "t6 full");
    run_seq(1'b1, "t6 half");
    check("t6 wr_cnt",  64'(wr_cnt),  64'(2));
    check("t6 rd_cnt",  64'(rd_cnt),  64'(4));
    check("t6 err_cnt", 64'(err_cnt), 64'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
